// File: rtl/fifo2axi_ctrl_pkg.sv
// Shared types and AXI constants for the FIFO2AXI burst controllers.
package fifo2axi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wr_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [12:0] AXI_4KB_BYTES = 13'd4096;

  // AxSIZE encoding for a full-width beat of strb_width bytes.
  function automatic logic [2:0] axi_size(input int unsigned strb_width);
    logic [2:0] size;
    size = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == strb_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/fifo2axi_wr_ctrl.sv
// Single-outstanding AXI4 INCR write-burst sequencer draining a FWFT data FIFO.
module fifo2axi_wr_ctrl
  import fifo2axi_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic [ID_WIDTH-1:0]   awid,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [LEN_WIDTH-1:0]  awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_WIDTH-1:0]   wid,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_WIDTH-1:0]   bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  done,
  output logic                  err,
  output logic                  busy
);

  localparam logic [2:0]          AXI_SIZE = axi_size(STRB_WIDTH);
  localparam logic [ID_WIDTH-1:0] OWN_ID   = ID_WIDTH'(AXI_ID);

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [12:0]           burst_end;
  logic                  cross_4kb;

  // Byte offset one past the last beat, within the 4KB page of the start address.
  assign burst_end = {1'b0, cmd_addr[11:0]}
                   + (13'(cmd_len) + 13'd1) * 13'(STRB_WIDTH);
  assign cross_4kb = burst_end > AXI_4KB_BYTES;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    fifo_rd_en = 1'b0;
    bready     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Hold off the next command while the previous completion is reported.
        cmd_ready = !done_q;
        if (cmd_valid && !done_q) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          if (cross_4kb) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_AW;
          end
        end
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) begin
          state_d = ST_W;
          cnt_d   = '0;
        end
      end
      ST_W: begin
        wvalid     = !fifo_empty;
        wlast      = (cnt_q == len_q);
        fifo_rd_en = wvalid && wready;
        if (fifo_rd_en) begin
          if (wlast) state_d = ST_B;
          else       cnt_d   = cnt_q + LEN_WIDTH'(1);
        end
      end
      ST_B: begin
        bready = 1'b1;
        if (bvalid) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = (bresp != AXI_RESP_OKAY) || (bid != OWN_ID);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign awid    = OWN_ID;
  assign wid     = OWN_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = AXI_SIZE;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = fifo_rdata;
  assign wstrb   = '1;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fifo2axi_wr_ctrl.sv
// Directed, table-driven bench for fifo2axi_wr_ctrl with a FIFO and AXI slave model.
module tb_fifo2axi_wr_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 4;
  localparam int LW = 4;

  logic          aclk, aresetn;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_rdata;
  logic [IW-1:0] awid, wid, bid;
  logic [AW-1:0] awaddr;
  logic [LW-1:0] awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst, bresp;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic          bvalid, bready;
  logic          done, err, busy;

  fifo2axi_wr_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
    .ID_WIDTH(IW), .LEN_WIDTH(LW), .AXI_ID(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .done(done), .err(err), .busy(busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            nwords;
    int            refill;
    int            aw_delay;
    logic [1:0]    bresp;
    logic [IW-1:0] bid;
    logic [DW-1:0] dbase;
    bit            exp_aw;
    int            exp_beats;
    bit            exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  int cyc;
  int aw_hs, aw_cnt, aw_bad, stall_w, beats, pops, pop_empty, wlast_beat, wlast_cnt;
  int wdata_bad, ready_bad, err_nodone, done_cnt, done_cyc, acc_cyc, gap23, last_hs_cyc;
  int refill_n, refill_empty, aw_delay_v;
  bit accepted, done_err, b_pending;
  logic [AW-1:0] exp_addr;
  logic [LW-1:0] exp_len, awlen_s;
  logic [2:0]    awsize_s;
  logic [1:0]    awburst_s, bresp_v;
  logic [IW-1:0] bid_v;
  logic [DW-1:0] dbase, refill_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    awready    = (aw_cnt >= aw_delay_v);
    wready     = 1'b1;
    bvalid     = b_pending;
    bresp      = bresp_v;
    bid        = bid_v;
  endtask

  // One clock: sample at negedge, update models after posedge.
  task automatic tick();
    bit pop_now;
    @(negedge aclk);
    cyc++;
    if (cmd_valid && cmd_ready) begin accepted = 1; acc_cyc = cyc; end
    if (cmd_ready && (busy || done)) ready_bad++;
    if (err && !done) err_nodone++;
    if (done) begin done_cnt++; done_err = err; done_cyc = cyc; end
    if (awvalid) begin
      if (awaddr !== exp_addr || awlen !== exp_len || !busy) aw_bad++;
      if (wvalid) stall_w++;
      if (awready) begin
        aw_hs++; awlen_s = awlen; awsize_s = awsize; awburst_s = awburst;
      end else aw_cnt++;
    end
    pop_now = fifo_rd_en;
    if (fifo_rd_en) begin pops++; if (fifo_empty) pop_empty++; end
    if (bvalid && bready) b_pending = 0;
    if (wvalid && wready) begin
      beats++;
      if (wdata !== dbase + DW'(beats - 1) || wstrb !== 4'hF) wdata_bad++;
      if (wlast) begin wlast_beat = beats; wlast_cnt++; b_pending = 1; end
      if (beats == 3) gap23 = cyc - last_hs_cyc - 1;
      last_hs_cyc = cyc;
    end
    if (fifo_empty && refill_n > 0) refill_empty++;
    @(posedge aclk);
    #1;
    if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (refill_n > 0 && refill_empty >= 5) begin
      for (int i = 0; i < refill_n; i++) fifo_q.push_back(refill_base + DW'(i));
      refill_n = 0;
    end
    drive_inputs();
  endtask

  task automatic setup(input vec_t v);
    aw_hs = 0; aw_cnt = 0; aw_bad = 0; stall_w = 0; beats = 0; pops = 0; pop_empty = 0;
    wlast_beat = 0; wlast_cnt = 0; wdata_bad = 0; ready_bad = 0; err_nodone = 0;
    done_cnt = 0; done_cyc = 0; acc_cyc = 0; gap23 = -1; last_hs_cyc = 0;
    accepted = 0; done_err = 0; b_pending = 0;
    exp_addr = v.addr; exp_len = v.len; dbase = v.dbase;
    aw_delay_v = v.aw_delay; bresp_v = v.bresp; bid_v = v.bid;
    fifo_q.delete();
    for (int i = 0; i < v.nwords; i++) fifo_q.push_back(v.dbase + DW'(i));
    refill_n = v.refill; refill_base = v.dbase + DW'(v.nwords); refill_empty = 0;
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len;
    drive_inputs();
  endtask

  task automatic run_vec(input vec_t v);
    setup(v);
    for (int k = 0; k < 200 && done_cnt == 0; k++) begin
      tick();
      if (accepted) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    tick();
    check({v.name, " accepted"}, 64'(accepted), 64'd1);
    check({v.name, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({v.name, " err"}, 64'(done_err), 64'(v.exp_err));
    check({v.name, " aw_handshakes"}, 64'(aw_hs), v.exp_aw ? 64'd1 : 64'd0);
    check({v.name, " w_beats"}, 64'(beats), 64'(v.exp_beats));
    check({v.name, " pops"}, 64'(pops), 64'(v.exp_beats));
    check({v.name, " wlast_beat"}, 64'(wlast_beat), 64'(v.exp_beats));
    check({v.name, " wlast_count"}, 64'(wlast_cnt), v.exp_beats > 0 ? 64'd1 : 64'd0);
    check({v.name, " wdata_errs"}, 64'(wdata_bad), 64'd0);
    check({v.name, " aw_unstable"}, 64'(aw_bad), 64'd0);
    check({v.name, " wvalid_in_aw"}, 64'(stall_w), 64'd0);
    check({v.name, " cmd_ready_busy"}, 64'(ready_bad), 64'd0);
    check({v.name, " err_without_done"}, 64'(err_nodone), 64'd0);
    check({v.name, " pop_on_empty"}, 64'(pop_empty), 64'd0);
    if (v.exp_aw) begin
      check({v.name, " awlen"}, 64'(awlen_s), 64'(v.len));
      check({v.name, " awsize"}, 64'(awsize_s), 64'd2);
      check({v.name, " awburst"}, 64'(awburst_s), 64'd1);
      check({v.name, " aw_stall_cycles"}, 64'(aw_cnt), 64'(v.aw_delay));
    end else begin
      check({v.name, " reject_latency"}, 64'(done_cyc - acc_cyc), 64'd1);
    end
    if (v.refill > 0) check({v.name, " empty_gap"}, 64'(gap23), 64'd5);
  endtask

  function automatic vec_t mk(input string name, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input int nwords, input int refill, input int aw_delay,
                              input logic [1:0] br, input logic [IW-1:0] b_id, input logic [DW-1:0] base,
                              input bit exp_aw, input int exp_beats, input bit exp_err);
    vec_t v;
    v.name = name; v.addr = addr; v.len = len; v.nwords = nwords; v.refill = refill;
    v.aw_delay = aw_delay; v.bresp = br; v.bid = b_id; v.dbase = base;
    v.exp_aw = exp_aw; v.exp_beats = exp_beats; v.exp_err = exp_err;
    return v;
  endfunction

  vec_t vecs[11];
  vec_t rst_v;

  initial begin
    vecs[0]  = mk("basic_len3",   32'h0000_1000, 4'd3,  4, 0, 0, 2'b00, 4'd0, 32'hA0,  1, 4,  0);
    vecs[1]  = mk("reject_4k",    32'h0000_0FF8, 4'd3,  0, 0, 0, 2'b00, 4'd0, 32'h00,  0, 0,  1);
    vecs[2]  = mk("slverr_len0",  32'h0000_2000, 4'd0,  1, 0, 0, 2'b10, 4'd0, 32'hB0,  1, 1,  1);
    vecs[3]  = mk("aw_stall7",    32'h0000_3000, 4'd2,  3, 0, 7, 2'b00, 4'd0, 32'hC0,  1, 3,  0);
    vecs[4]  = mk("exact_4k_end", 32'h0000_0FF0, 4'd3,  4, 0, 0, 2'b00, 4'd0, 32'hD0,  1, 4,  0);
    vecs[5]  = mk("last_word_4k", 32'h0000_4FFC, 4'd0,  1, 0, 0, 2'b00, 4'd0, 32'hE0,  1, 1,  0);
    vecs[6]  = mk("reject_by_4",  32'h0000_5FFC, 4'd1,  0, 0, 0, 2'b00, 4'd0, 32'h00,  0, 0,  1);
    vecs[7]  = mk("max_len15",    32'h0000_6000, 4'd15, 16, 0, 0, 2'b00, 4'd0, 32'h100, 1, 16, 0);
    vecs[8]  = mk("bid_mismatch", 32'h0000_7000, 4'd1,  2, 0, 0, 2'b00, 4'd3, 32'h200, 1, 2,  1);
    vecs[9]  = mk("decerr",       32'h0000_8000, 4'd0,  1, 0, 0, 2'b11, 4'd0, 32'h300, 1, 1,  1);
    vecs[10] = mk("fifo_gap",     32'h0000_1000, 4'd3,  2, 2, 0, 2'b00, 4'd0, 32'hA0,  1, 4,  0);

    cyc = 0; aw_cnt = 0; aw_delay_v = 0; b_pending = 0; bresp_v = '0; bid_v = '0; refill_n = 0;
    fifo_q.delete();
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    drive_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("reset awvalid", 64'(awvalid), 64'd0);
    check("reset wvalid", 64'(wvalid), 64'd0);
    check("reset bready", 64'(bready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset err", 64'(err), 64'd0);
    check("reset fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Reset during the W phase of a len=7 burst, then a fresh burst.
    rst_v = mk("rst_mid", 32'h0000_9000, 4'd7, 8, 0, 0, 2'b00, 4'd0, 32'h400, 1, 8, 0);
    setup(rst_v);
    for (int k = 0; k < 100 && beats < 2; k++) begin
      tick();
      if (accepted) cmd_valid = 1'b0;
    end
    check("rst_mid reached beat2", 64'(beats), 64'd2);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_mid awvalid", 64'(awvalid), 64'd0);
    check("rst_mid wvalid", 64'(wvalid), 64'd0);
    check("rst_mid bready", 64'(bready), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    check("rst_mid fifo_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_mid cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1;
    run_vec(mk("after_rst", 32'h0000_A000, 4'd1, 2, 0, 0, 2'b00, 4'd0, 32'h500, 1, 2, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
